// File: rtl/mmul_io_ctrl.sv
// mmul_io_ctrl: host-side sequencer for the 256-bit modular multiplier.
// Streams three 16-word operands (A, B, P) from the host into the datapath
// registers, runs the multiplier until it reports ready, then streams the
// 16-word result out of register C by rotating it one word per handshake.
module mmul_io_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] datain,
  output logic        rega_we,
  output logic        rega_sel,
  output logic        regb_we,
  output logic        regb_cyc,
  output logic        regp_we,
  output logic        regp_cyc,
  output logic        mmul_en,
  input  logic        mmul_rdy,
  input  logic [15:0] regcout,
  output logic        regc_cyc
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LOAD_P,
    RUN,
    UNLOAD,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  // High only during the first RUN cycle, when mmul_rdy may still be stale
  logic       run_first_q, run_first_d;

  // The load bus and result port are straight wires; only the enables are sequenced
  assign datain   = din;
  assign dout     = regcout;
  assign rega_sel = 1'b0;
  assign regb_cyc = 1'b0;
  assign regp_cyc = 1'b0;

  // Next-state, word counter and handshake/enable decode; abort overrides all
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    run_first_d = 1'b0;
    din_ready   = 1'b0;
    dout_valid  = 1'b0;
    rega_we     = 1'b0;
    regb_we     = 1'b0;
    regp_we     = 1'b0;
    mmul_en     = 1'b0;
    regc_cyc    = 1'b0;
    done        = 1'b0;
    busy        = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_A;
          wcnt_d  = 4'd0;
        end
      end

      LOAD_A: begin
        din_ready = 1'b1;
        if (din_valid) begin
          rega_we = 1'b1;
          wcnt_d  = wcnt_q + 4'd1;
          if (wcnt_q == 4'd15) begin
            state_d = LOAD_B;
            wcnt_d  = 4'd0;
          end
        end
      end

      LOAD_B: begin
        din_ready = 1'b1;
        if (din_valid) begin
          regb_we = 1'b1;
          wcnt_d  = wcnt_q + 4'd1;
          if (wcnt_q == 4'd15) begin
            state_d = LOAD_P;
            wcnt_d  = 4'd0;
          end
        end
      end

      LOAD_P: begin
        din_ready = 1'b1;
        if (din_valid) begin
          regp_we = 1'b1;
          wcnt_d  = wcnt_q + 4'd1;
          if (wcnt_q == 4'd15) begin
            state_d     = RUN;
            wcnt_d      = 4'd0;
            run_first_d = 1'b1;
          end
        end
      end

      RUN: begin
        mmul_en = 1'b1;
        if (!run_first_q && mmul_rdy) begin
          state_d = UNLOAD;
          wcnt_d  = 4'd0;
        end
      end

      UNLOAD: begin
        dout_valid = 1'b1;
        if (dout_ready) begin
          regc_cyc = 1'b1;
          wcnt_d   = wcnt_q + 4'd1;
          if (wcnt_q == 4'd15) begin
            state_d = DONE;
            wcnt_d  = 4'd0;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
        wcnt_d  = 4'd0;
      end

      default: begin
        state_d = IDLE;
        wcnt_d  = 4'd0;
      end
    endcase

    if (abort) begin
      state_d     = IDLE;
      wcnt_d      = 4'd0;
      run_first_d = 1'b0;
      din_ready   = 1'b0;
      dout_valid  = 1'b0;
      rega_we     = 1'b0;
      regb_we     = 1'b0;
      regp_we     = 1'b0;
      mmul_en     = 1'b0;
      regc_cyc    = 1'b0;
    end
  end

  // State, counter and first-RUN-cycle flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= 4'd0;
      run_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      run_first_q <= run_first_d;
    end
  end

endmodule

// File: tb/tb_mmul_io_ctrl.sv
// tb_mmul_io_ctrl: scoreboard bench for mmul_io_ctrl.
// The driver pushes expected load words, result words and RUN lengths into
// queues; an independent monitor pops and compares them as the DUT shows them.
// Register C is modelled as 16 words read through a rotation offset.
module tb_mmul_io_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] din, dout, datain, regcout;
  logic        din_valid, din_ready, dout_valid, dout_ready;
  logic        busy, done;
  logic        rega_we, rega_sel, regb_we, regb_cyc, regp_we, regp_cyc;
  logic        mmul_en, mmul_rdy, regc_cyc;

  int nCompared = 0;
  int nMismatch = 0;
  int expDone   = 0;
  int doneSeen  = 0;

  logic [15:0] cWords [16];
  logic [3:0]  rot = 4'd0;

  logic [17:0] loadQ [$];
  logic [15:0] doutQ [$];
  int          runQ  [$];

  mmul_io_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done),
    .datain     (datain),
    .rega_we    (rega_we),
    .rega_sel   (rega_sel),
    .regb_we    (regb_we),
    .regb_cyc   (regb_cyc),
    .regp_we    (regp_we),
    .regp_cyc   (regp_cyc),
    .mmul_en    (mmul_en),
    .mmul_rdy   (mmul_rdy),
    .regcout    (regcout),
    .regc_cyc   (regc_cyc)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Register C model: a rotate advances the word presented on regcout
  always @(posedge clk) begin
    if (regc_cyc === 1'b1) rot <= rot + 4'd1;
  end

  assign regcout = cWords[rot];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input string detail);
    nCompared++;
    nMismatch++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand word and hold it until the DUT takes it
  task automatic sendWord(input logic [15:0] val, input logic [1:0] sel);
    int cyc;
    bit hs;
    din       = val;
    din_valid = 1'b1;
    loadQ.push_back({sel, val});
    cyc = 0;
    hs  = 1'b0;
    while (!hs && cyc < 50) begin
      @(negedge clk);
      hs = (din_ready === 1'b1);
      checkOutput("busy_during_load", busy, 1);
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("load_handshake", hs, 1);
    din_valid = 1'b0;
  endtask

  // One transaction: load A/B/P, run, unload, with optional stall/backpressure/abort/reset
  task automatic applyStimulus(input bit seqWords, input bit stallB, input int runLen,
                               input bit earlyRdy, input bit startInRun, input int bpWord,
                               input int abortP, input int rstWord, input bit randomReady);
    logic [15:0] val;
    logic [3:0]  idx;
    int          hs, cyc, bpLeft;
    bit          bpDone;

    for (int i = 0; i < 16; i++) cWords[i] = 16'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;

    for (int k = 0; k < 48; k++) begin
      val = seqWords ? 16'(k + 1) : 16'($urandom);
      if (abortP >= 0 && k == 32 + abortP) begin
        din       = val;
        din_valid = 1'b1;
        abort     = 1'b1;
        tick();
        abort     = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_abort", busy, 0);
        checkOutput("din_ready_after_abort", din_ready, 0);
        tick();
        return;
      end
      if (stallB && k == 16 + 7) begin
        din_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          checkOutput("stall_regb_we", regb_we, 0);
          checkOutput("stall_din_ready", din_ready, 1);
          tick();
        end
      end
      sendWord(val, 2'(k / 16));
    end

    runQ.push_back(runLen);
    for (int i = 0; i < 16; i++) begin
      idx = rot + 4'(i);
      doutQ.push_back(cWords[idx]);
    end

    for (int c = 1; c <= runLen; c++) begin
      mmul_rdy = (c == runLen) || (c == 1 && earlyRdy);
      start    = startInRun && (c == 2);
      tick();
    end
    mmul_rdy = 1'b0;
    start    = 1'b0;

    hs     = 0;
    cyc    = 0;
    bpLeft = 0;
    bpDone = 1'b0;
    while (hs < 16 && cyc < 300) begin
      if (rstWord >= 0 && hs == rstWord) begin
        dout_ready = 1'b0;
        rst        = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_unload_outputs",
                    {busy, done, din_ready, dout_valid, mmul_en, rega_we, regb_we, regp_we, regc_cyc}, 0);
        tick();
        return;
      end
      if (bpWord == hs && !bpDone) begin
        bpLeft = 4;
        bpDone = 1'b1;
      end
      if (bpLeft > 0) begin
        dout_ready = 1'b0;
        bpLeft--;
      end else begin
        dout_ready = randomReady ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(negedge clk);
      if (dout_valid === 1'b1 && dout_ready === 1'b1) hs++;
      tick();
      cyc++;
    end
    dout_ready = 1'b0;
    checkOutput("unload_handshakes", hs, 16);
    expDone++;

    @(negedge clk);
    checkOutput("done_pulse", done, 1);
    checkOutput("busy_in_done", busy, 1);
    tick();
    @(negedge clk);
    checkOutput("idle_after_done", {busy, done}, 0);
    tick();
  endtask

  // Monitor: pops the scoreboard queues whenever the DUT shows a write, result or done
  initial begin
    int          runCount;
    int          wordCount;
    int          nWe;
    logic [17:0] expLoad;
    logic [1:0]  actSel;
    runCount  = 0;
    wordCount = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 || abort === 1'b1) begin
        if (rst !== 1'b1)
          checkOutput("abort_enables",
                      {din_ready, dout_valid, mmul_en, rega_we, regb_we, regp_we, regc_cyc}, 0);
        loadQ.delete();
        doutQ.delete();
        runQ.delete();
        runCount  = 0;
        wordCount = 0;
      end else begin
        checkOutput("datain_follows_din", datain, din);
        checkOutput("fixed_zero_controls", {rega_sel, regb_cyc, regp_cyc}, 0);
        nWe = int'(rega_we === 1'b1) + int'(regb_we === 1'b1) + int'(regp_we === 1'b1);
        if (nWe > 1) begin
          checkOutput("single_write_enable", nWe, 1);
        end else if (nWe == 1) begin
          actSel = (rega_we === 1'b1) ? 2'd0 : (regb_we === 1'b1) ? 2'd1 : 2'd2;
          if (loadQ.size() == 0) begin
            reportFail("unexpected_write", "write enable with no word outstanding");
          end else begin
            expLoad = loadQ.pop_front();
            checkOutput("write_target", actSel, expLoad[17:16]);
            checkOutput("load_word", datain, expLoad[15:0]);
          end
        end
        if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
          checkOutput("regc_cyc_on_handshake", regc_cyc, 1);
          if (doutQ.size() == 0) reportFail("unexpected_result", "result handshake with no word expected");
          else checkOutput("result_word", dout, doutQ.pop_front());
          wordCount++;
        end else begin
          checkOutput("regc_cyc_without_handshake", regc_cyc, 0);
          if (dout_valid === 1'b1 && doutQ.size() > 0) checkOutput("result_held", dout, doutQ[0]);
        end
        if (mmul_en === 1'b1) runCount++;
        if (done === 1'b1) begin
          doneSeen++;
          if (runQ.size() == 0) begin
            reportFail("unexpected_done", "done with no transaction outstanding");
          end else begin
            checkOutput("run_length", runCount, runQ.pop_front());
            checkOutput("result_word_count", wordCount, 16);
          end
          runCount  = 0;
          wordCount = 0;
        end
      end
    end
  end

  // Directed scenarios followed by randomized transactions
  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    din        = 16'd0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    mmul_rdy   = 1'b0;
    for (int i = 0; i < 16; i++) cWords[i] = 16'd0;
    repeat (3) tick();
    @(negedge clk);
    checkOutput("reset_outputs",
                {busy, done, din_ready, dout_valid, mmul_en, rega_we, regb_we, regp_we, regc_cyc}, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] full transaction");
    applyStimulus(1'b1, 1'b0, 5, 1'b0, 1'b0, -1, -1, -1, 1'b0);
    $display("[TB] input stall and output backpressure");
    applyStimulus(1'b0, 1'b1, 3, 1'b0, 1'b0, 2, -1, -1, 1'b0);
    $display("[TB] early ready and start while busy");
    applyStimulus(1'b0, 1'b0, 4, 1'b1, 1'b1, -1, -1, -1, 1'b0);
    $display("[TB] abort in LOAD_P");
    applyStimulus(1'b0, 1'b0, 3, 1'b0, 1'b0, -1, 9, -1, 1'b0);
    $display("[TB] reset during UNLOAD");
    applyStimulus(1'b0, 1'b0, 3, 1'b0, 1'b0, -1, -1, 5, 1'b0);
    $display("[TB] clean transaction after reset");
    applyStimulus(1'b0, 1'b0, 2, 1'b0, 1'b0, -1, -1, -1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(2, 10)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)), -1, -1, 1'b1);
    end

    repeat (3) tick();
    checkOutput("done_count", doneSeen, expDone);
    checkOutput("load_queue_drained", loadQ.size(), 0);
    checkOutput("result_queue_drained", doutQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/mmul_io_ctrl.md
MMUL_IO_CTRL -- requirements
Module: mmul_io_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports in this order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
REQ-002 The block SHALL have these host-side ports:
- start  in  1  begin a transaction; honoured only in IDLE
- abort  in  1  return to IDLE from any state
- din  in  16  operand word from host
- din_valid  in  1  din holds a word
- din_ready  out  1  block accepts din this cycle
- dout  out  16  result word to host
- dout_valid  out  1  dout holds a result word
- dout_ready  in  1  host accepts dout this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the transaction completes
REQ-003 The block SHALL have these datapath-side ports:
- datain  out  16  word to the datapath load bus
- rega_we  out  1  A register write enable
- rega_sel  out  1  A register mode select; always 0 (load mode)
- regb_we  out  1  B register write enable
- regb_cyc  out  1  B register rotate; always 0
- regp_we  out  1  P register write enable
- regp_cyc  out  1  P register rotate; always 0
- mmul_en  out  1  multiply enable
- mmul_rdy  in  1  multiply complete
- regcout  in  16  low word of the result register C
- regc_cyc  out  1  rotate C by 16 bits

Function
REQ-004 The FSM SHALL have states IDLE, LOAD_A, LOAD_B, LOAD_P, RUN, UNLOAD and DONE.
REQ-005 The block SHALL have one 4-bit word counter, wcnt, which SHALL be cleared on every state entry.
REQ-006 IDLE SHALL go to LOAD_A when start=1; otherwise it SHALL stay in IDLE.
REQ-007 In the LOAD states, din_ready SHALL be 1, and a word is accepted in any cycle with din_valid=1 and din_ready=1.
REQ-008 datain SHALL equal din combinationally at all times.
REQ-009 In a cycle where a word is accepted:
- in LOAD_A, rega_we SHALL be 1;
- in LOAD_B, regb_we SHALL be 1;
- in LOAD_P, regp_we SHALL be 1;
- wcnt SHALL increment.
All three write enables SHALL be 0 in every other cycle.
REQ-010 Operands SHALL be loaded least-significant word first, 16 words (256 bits) per operand.
REQ-011 The 16th accepted word (wcnt=15) SHALL advance the FSM: LOAD_A to LOAD_B, LOAD_B to LOAD_P, LOAD_P to RUN.
REQ-012 din_valid=0 SHALL stall the FSM with no write enable asserted and wcnt held.
REQ-013 In RUN, mmul_en SHALL be 1 in every cycle.
REQ-014 mmul_rdy SHALL be ignored in the first RUN cycle; in any later RUN cycle, mmul_rdy=1 SHALL move the FSM to UNLOAD.
REQ-015 RUN SHALL have no timeout.
REQ-016 In UNLOAD, dout_valid SHALL be 1 and dout SHALL equal regcout combinationally.
REQ-017 In any UNLOAD cycle with dout_valid=1 and dout_ready=1, regc_cyc SHALL be 1 for that cycle and wcnt SHALL increment.
REQ-018 Result words SHALL be delivered least-significant word first.
REQ-019 The 16th result handshake SHALL move the FSM to DONE; after 16 rotations, C holds its original value.
REQ-020 dout_ready=0 SHALL hold dout stable, with regc_cyc=0 and wcnt held.
REQ-021 DONE SHALL last exactly one cycle with done=1, then the FSM SHALL go to IDLE.
REQ-022 start SHALL be ignored in every state except IDLE.
REQ-023 When abort=1, the FSM SHALL go to IDLE on the next edge with wcnt cleared, and all enables SHALL be 0 during the abort cycle; abort takes priority over every other transition.
REQ-024 Minimum transaction latency, from start sampled to done, SHALL be 48 load cycles + RUN length + 16 unload cycles + 1 DONE cycle + 1 IDLE-exit cycle.

Reset
REQ-025 rst=1 SHALL force, on the next edge: state IDLE, wcnt=0, and busy, done, din_ready, dout_valid, mmul_en, all write enables and regc_cyc all 0.
REQ-026 rst SHALL take priority over abort and start.
REQ-027 rst asserted mid-transaction SHALL discard all progress.

Verification
REQ-028 Full transaction: start, then 48 back-to-back words 0x0001..0x0030, then mmul_rdy=1 on RUN cycle 5, regcout driven from a 16-word model -> each datapath write enable is high for exactly 16 cycles with datain matching din, mmul_en is high for 5 cycles, 16 dout words appear in order, and done pulses once.
REQ-029 Input stall: din_valid low for 3 cycles after word 7 of B -> regb_we=0 during the stall and wcnt holds at 7; loading then resumes.
REQ-030 Output backpressure: dout_ready low for 4 cycles at result word 2 -> dout is constant, regc_cyc=0, and delivery resumes without duplicate or missing words.
REQ-031 Early ready: mmul_rdy=1 already in the first RUN cycle, then 0 -> the block stays in RUN until mmul_rdy=1 in a later cycle.
REQ-032 Abort and reset: abort=1 in LOAD_P at wcnt=9 -> IDLE next cycle with busy=0; rst=1 during UNLOAD -> all outputs 0 next cycle, and a following start runs a clean transaction.
REQ-033 Start while busy: start=1 during RUN -> no state change and no counter change.
